// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch_pc_r32i instruction-fetch stage.
package fetch_pkg;

   // ADDI x0, x0, 0: the canonical RV32I no-op, used to fill an invalid IF/ID entry.
   localparam logic [31:0] NOP_INS = 32'h00000013;

   // Program counter value loaded on reset unless the top overrides it.
   localparam logic [31:0] RESET_VEC_DEFAULT = 32'h00000000;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      MISS_WAIT = 2'd1,
      BUBBLE    = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: instructions loaded into IF/ID and cache stall cycles.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_cnt #(
   parameter int unsigned dataW = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fetchInc,
   input  logic             stallInc,
   output logic [dataW-1:0] FetchCount,
   output logic [dataW-1:0] StallCount
);

   logic [dataW-1:0] fetchCountQ, fetchCountD;
   logic [dataW-1:0] stallCountQ, stallCountD;

   // Next-state: both counters wrap silently modulo 2^dataW.
   always_comb begin
      fetchCountD = fetchCountQ;
      stallCountD = stallCountQ;
      if (fetchInc) fetchCountD = fetchCountQ + dataW'(1);
      if (stallInc) stallCountD = stallCountQ + dataW'(1);
   end

   // Counter registers, cleared by the asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetchCountQ <= '0;
         stallCountQ <= '0;
      end else begin
         fetchCountQ <= fetchCountD;
         stallCountQ <= stallCountD;
      end
   end

   assign FetchCount = fetchCountQ;
   assign StallCount = stallCountQ;

endmodule

// File: rtl/fetch_pc_r32i.sv
// Instruction-fetch stage: owns the PC, drives the instruction-cache address and fills
// the IF/ID pipeline register. Priority per edge: redirect > cache stall > decode hold
// > normal issue.
// Optional build macro FETCH_PERF_EN adds FetchCount / StallCount outputs.
module fetch_pc_r32i
   import fetch_pkg::*;
#(
   parameter int unsigned      dataW     = 32,
   parameter int unsigned      PC_STEP   = 1,
   parameter logic [dataW-1:0] RESET_VEC = dataW'(RESET_VEC_DEFAULT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             InsCacheStall,
   input  logic [dataW-1:0] OutputIns,
   input  logic             RedirectValid,
   input  logic [dataW-1:0] RedirectAddr,
   input  logic             DecodeHold,
   output logic [dataW-1:0] ProgAddr,
   output logic             IfIdValid,
   output logic [dataW-1:0] IfIdIns,
   output logic [dataW-1:0] IfIdPC
`ifdef FETCH_PERF_EN
   ,
   output logic [dataW-1:0] FetchCount,
   output logic [dataW-1:0] StallCount
`endif
);

   localparam logic [dataW-1:0] NopIns = dataW'(NOP_INS);
   localparam logic [dataW-1:0] PcStep = dataW'(PC_STEP);

   fetch_state_t     stateQ, stateD;
   logic [dataW-1:0] pcQ, pcD;
   logic             validQ, validD;
   logic [dataW-1:0] insQ, insD;
   logic [dataW-1:0] ifPcQ, ifPcD;

   // Next-state for PC, IF/ID entry and FSM; every path defaults to holding.
   always_comb begin
      stateD = stateQ;
      pcD    = pcQ;
      validD = validQ;
      insD   = insQ;
      ifPcD  = ifPcQ;

      if (RedirectValid) begin
         // A redirect discards any outstanding miss: the cache sees the new PC next cycle.
         pcD    = RedirectAddr;
         validD = 1'b0;
         insD   = NopIns;
         stateD = BUBBLE;
      end else if (InsCacheStall) begin
         // PC frozen so the cache can refill against a stable address. Once decode has
         // taken the current entry, drop valid so it is not issued twice.
         stateD = MISS_WAIT;
         if (!DecodeHold) validD = 1'b0;
      end else if (DecodeHold) begin
         // Back-pressure: nothing moves, FSM stays where it is.
         stateD = stateQ;
      end else begin
         // Hit with decode ready. Covers FETCH, MISS_WAIT exit and BUBBLE exit alike.
         insD   = OutputIns;
         ifPcD  = pcQ;
         validD = 1'b1;
         pcD    = pcQ + PcStep;
         stateD = FETCH;
      end
   end

   // State registers; reset returns to FETCH at the reset vector with an empty IF/ID.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ <= FETCH;
         pcQ    <= RESET_VEC;
         validQ <= 1'b0;
         insQ   <= NopIns;
         ifPcQ  <= '0;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
         validQ <= validD;
         insQ   <= insD;
         ifPcQ  <= ifPcD;
      end
   end

   assign ProgAddr  = pcQ;
   assign IfIdValid = validQ;
   assign IfIdIns   = insQ;
   assign IfIdPC    = ifPcQ;

`ifdef FETCH_PERF_EN
   logic fetchLoad;

   // A valid IF/ID load happens exactly on the normal-issue path.
   assign fetchLoad = !RedirectValid && !InsCacheStall && !DecodeHold;

   fetch_perf_cnt #(
      .dataW(dataW)
   ) uPerfCnt (
      .clock     (clock),
      .reset     (reset),
      .fetchInc  (fetchLoad),
      .stallInc  (InsCacheStall),
      .FetchCount(FetchCount),
      .StallCount(StallCount)
   );
`endif

endmodule

// File: doc/fetch_pc_r32i.md
Name: fetch_pc_r32i

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction cache.
- Owns the program counter and drives the cache address (ProgAddr); honours the cache stall (InsCacheStall).
- Captures the returned instruction (OutputIns) into the IF/ID pipeline register consumed by decode.
- Handles branch/jump redirects from execute and back-pressure (hold) from decode.

Parameters:
- dataW, 32, instruction and address width.
- PC_STEP, 1, PC increment per fetched instruction; the cache is word-indexed, so the default is 1.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- InsCacheStall  input  1  cache miss or refill in progress; OutputIns is invalid while high.
- OutputIns  input  dataW  instruction from the cache for the current ProgAddr.
- RedirectValid  input  1  execute requests a PC change this cycle.
- RedirectAddr  input  dataW  new PC, taken verbatim.
- DecodeHold  input  1  decode cannot accept a new IF/ID entry.
- ProgAddr  output  dataW  address to the cache; combinational copy of the PC register.
- IfIdValid  output  1  IF/ID entry is valid.
- IfIdIns  output  dataW  registered instruction.
- IfIdPC  output  dataW  PC of IfIdIns.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - PC = RESET_VEC, IfIdValid = 0, IfIdIns = NOP (32'h00000013), IfIdPC = 0, state = FETCH.
- FSM states:
  - FETCH: normal issue.
  - MISS_WAIT: cache stalled.
  - BUBBLE: one cycle after a redirect.
- Per-cycle priority, evaluated at the rising edge:
  1. RedirectValid:
     - PC <= RedirectAddr; IfIdValid <= 0; IfIdIns <= NOP; next state BUBBLE.
     - Overrides stall and hold in every state.
  2. InsCacheStall:
     - PC and IF/ID hold; next state MISS_WAIT.
     - If decode has consumed the entry (DecodeHold = 0), IfIdValid <= 0 so the entry is not re-issued.
  3. DecodeHold:
     - PC and the whole IF/ID entry hold; state unchanged.
  4. Otherwise:
     - IfIdIns <= OutputIns; IfIdPC <= PC; IfIdValid <= 1.
     - PC <= PC + PC_STEP, modulo 2^dataW (wraps from max to 0 with no flag); next state FETCH.
- Per-state transitions:
  - MISS_WAIT → FETCH: on the first edge with InsCacheStall = 0 and no hold. The instruction is captured that same edge, so it enters IF/ID the cycle after the stall drops.
  - BUBBLE: always presents IfIdValid = 0 for one cycle; leaves by the same rules as FETCH.
- Latency: PC to IF/ID is one cycle on a hit. A redirect costs one bubble plus any miss time.
- Simultaneous events:
  - Redirect together with a stall: PC still loads RedirectAddr. The cache then sees the new address; the stale miss is discarded.
  - Redirect while in MISS_WAIT: same behaviour.
- Reset mid-stall: the FSM returns to FETCH at RESET_VEC. No partial IF/ID content survives.
- ProgAddr is stable for the whole of any stall cycle. The cache relies on this for refill.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - FetchCount (dataW): increments on each valid IF/ID load.
  - StallCount (dataW): increments on each cycle with InsCacheStall = 1.
- Both counters reset to 0 and wrap modulo 2^dataW.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INS = 32'h00000013.
  - Enum fetch_state_t {FETCH, MISS_WAIT, BUBBLE}.
  - Default RESET_VEC constant.
- Sub-module fetch_perf_cnt holds the two counters; it is instantiated only under FETCH_PERF_EN.
- The PC and IF/ID logic stay in the top module.

Test Plan:
- Reset then free run, no stall, OutputIns = ProgAddr + 100:
  - ProgAddr = 0,1,2,3 on successive cycles.
  - IF/ID shows (Ins,PC) = (100,0),(101,1),(102,2), with IfIdValid low only in cycle 0.
- InsCacheStall high for 8 cycles at PC = 0:
  - ProgAddr held at 0; IfIdValid = 0 throughout.
  - After the stall drops, IfIdIns = OutputIns, IfIdPC = 0, and ProgAddr = 1 the next cycle.
- Redirect to 32 at PC = 6:
  - Next cycle ProgAddr = 32, IfIdValid = 0, IfIdIns = NOP.
  - The cycle after, IfIdPC = 32.
- Redirect to 4 asserted during a stall:
  - ProgAddr = 4 next cycle; the stale entry is never made valid.
  - Under FETCH_PERF_EN, StallCount counts every stall cycle.
- DecodeHold high 3 cycles at PC = 2:
  - IfIdIns and IfIdPC frozen; ProgAddr = 3 held.
  - No instruction lost or duplicated after release.
- PC = 32'hFFFFFFFF, no stall:
  - Next ProgAddr = 0.
  - Asynchronous reset asserted mid-cycle: outputs return to reset values before the next edge.
